// File: rtl/incr_adc_pkg.sv
// ---------------------------------------------------------------------------
// incr_adc_pkg : shared types and helpers for the incremental-ADC decimator
// Revision     : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package incr_adc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RESET = 2'd1,
    INTEG = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int unsigned OSR_LOG2_MIN = 2;

  function automatic int unsigned acc_w(input int unsigned osr_log2_max);
    return 2 * osr_log2_max;
  endfunction

  // Below OSR_LOG2_MIN the second integrator yields too few codes to be useful.
  function automatic int unsigned clamp_osr(input int unsigned osr,
                                            input int unsigned osr_max);
    if (osr < OSR_LOG2_MIN) begin
      return OSR_LOG2_MIN;
    end
    if (osr > osr_max) begin
      return osr_max;
    end
    return osr;
  endfunction

endpackage

`default_nettype wire

// File: rtl/decim_cic2_core.sv
// ---------------------------------------------------------------------------
// decim_cic2_core : two cascaded integrators fed by the 1-bit modulator stream
// Revision        : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module decim_cic2_core #(
  parameter int S1_W  = 11,
  parameter int ACC_W = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_i,
  input  logic             en_i,
  input  logic             data_i,
  output logic [S1_W-1:0]  s1_o,
  output logic [ACC_W-1:0] s2_o
);

  logic [S1_W-1:0]  s1_q, s1_d;
  logic [ACC_W-1:0] s2_q, s2_d;

  // s2 accumulates the freshly updated s1, giving weights N..1 on d_1..d_N.
  always_comb begin
    s1_d = s1_q + S1_W'(data_i);
    s2_d = s2_q + ACC_W'(s1_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= '0;
      s2_q <= '0;
    end else if (clear_i) begin
      s1_q <= '0;
      s2_q <= '0;
    end else if (en_i) begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign s1_o = s1_q;
  assign s2_o = s2_q;

endmodule

`default_nettype wire

// File: rtl/incr_adc_decimator.sv
// ---------------------------------------------------------------------------
// incr_adc_decimator : conversion sequencer, scaling and saturation around
//                      a second-order integrator cascade
// Revision           : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module incr_adc_decimator
  import incr_adc_pkg::*;
#(
  parameter  int OSR_LOG2_MAX = 10,
  parameter  int OUT_W        = 16,
  localparam int ACC_W        = int'(acc_w(OSR_LOG2_MAX)),
  localparam int S1_W         = OSR_LOG2_MAX + 1,
  localparam int OSR_W        = $clog2(OSR_LOG2_MAX + 1),
  localparam int SH_W         = $clog2(ACC_W)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             mode,
  input  logic             start,
  input  logic [OSR_W-1:0] osr_log2,
  input  logic [SH_W-1:0]  shift,
  input  logic             data_in,
  output logic             int_rst,
  output logic             busy,
  output logic [OUT_W-1:0] data_out,
  output logic             new_data,
  output logic             sat
);

  state_e             state_q;
  logic [OSR_W-1:0]   osr_q;
  logic [SH_W-1:0]    shift_q;
  logic [S1_W-1:0]    count_q;
  logic               int_rst_q;
  logic               busy_q;
  logic [OUT_W-1:0]   data_out_q;
  logic               new_data_q;
  logic               sat_q;

  logic               clear;
  logic               integ_en;
  logic [S1_W-1:0]    s1_unused;
  logic [ACC_W-1:0]   s2;
  logic [S1_W-1:0]    last_count;
  logic               last_sample;
  logic [ACC_W-1:0]   scaled;
  logic [OUT_W-1:0]   result_d;
  logic               sat_d;

  assign clear    = (state_q == RESET);
  assign integ_en = (state_q == INTEG);

  decim_cic2_core #(
    .S1_W  (S1_W),
    .ACC_W (ACC_W)
  ) u_core (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear_i (clear),
    .en_i    (integ_en),
    .data_i  (data_in),
    .s1_o    (s1_unused),
    .s2_o    (s2)
  );

  assign last_count  = (S1_W'(1) << osr_q) - S1_W'(1);
  assign last_sample = (count_q == last_count);
  assign scaled      = s2 >> shift_q;

  generate
    if (ACC_W > OUT_W) begin : g_sat_narrow
      assign sat_d    = |scaled[ACC_W-1:OUT_W];
      assign result_d = sat_d ? {OUT_W{1'b1}} : scaled[OUT_W-1:0];
    end else begin : g_sat_wide
      assign sat_d    = 1'b0;
      assign result_d = OUT_W'(scaled);
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (integ_en) begin
      count_q <= count_q + S1_W'(1);
    end
  end

  // Outputs are updated alongside the state so each reflects the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      osr_q      <= '0;
      shift_q    <= '0;
      int_rst_q  <= 1'b1;
      busy_q     <= 1'b0;
      data_out_q <= '0;
      new_data_q <= 1'b0;
      sat_q      <= 1'b0;
    end else begin
      new_data_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (enable && (start || mode)) begin
            state_q <= RESET;
            busy_q  <= 1'b1;
          end
        end
        RESET: begin
          if (!enable) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            state_q   <= INTEG;
            int_rst_q <= 1'b0;
            osr_q     <= OSR_W'(clamp_osr(32'(osr_log2), OSR_LOG2_MAX));
            shift_q   <= shift;
          end
        end
        INTEG: begin
          if (!enable) begin
            state_q   <= IDLE;
            int_rst_q <= 1'b1;
            busy_q    <= 1'b0;
          end else if (last_sample) begin
            state_q   <= DONE;
            int_rst_q <= 1'b1;
          end
        end
        DONE: begin
          if (enable) begin
            data_out_q <= result_d;
            sat_q      <= sat_d;
            new_data_q <= 1'b1;
          end
          if (enable && mode) begin
            state_q <= RESET;
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q   <= IDLE;
          int_rst_q <= 1'b1;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  assign int_rst  = int_rst_q;
  assign busy     = busy_q;
  assign data_out = data_out_q;
  assign new_data = new_data_q;
  assign sat      = sat_q;

endmodule

`default_nettype wire

// File: tb/tb_incr_adc_decimator.sv
// ---------------------------------------------------------------------------
// tb_incr_adc_decimator : directed checks of incr_adc_decimator (OUT_W=12)
// Revision              : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_incr_adc_decimator;

  localparam int OUT_W = 12;

  logic              clk;
  logic              rst_n;
  logic              enable;
  logic              mode;
  logic              start;
  logic [3:0]        osr_log2;
  logic [4:0]        shift;
  logic              data_in;
  logic              int_rst;
  logic              busy;
  logic [OUT_W-1:0]  data_out;
  logic              new_data;
  logic              sat;

  int total;
  int bad;

  incr_adc_decimator #(
    .OSR_LOG2_MAX (10),
    .OUT_W        (OUT_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable   (enable),
    .mode     (mode),
    .start    (start),
    .osr_log2 (osr_log2),
    .shift    (shift),
    .data_in  (data_in),
    .int_rst  (int_rst),
    .busy     (busy),
    .data_out (data_out),
    .new_data (new_data),
    .sat      (sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // kind: 0 zeros, 1 ones, 2 first sample only, 3 last sample only, 4 alternating from 1
  function automatic logic pat(input int kind, input int k, input int n);
    case (kind)
      1:       return 1'b1;
      2:       return (k == 1);
      3:       return (k == n);
      4:       return (k % 2) == 1;
      default: return 1'b0;
    endcase
  endfunction

  // Single-shot conversion; edge index e counts rising edges from E0 (start sampled).
  task automatic run_conv(input int osr_in, input int sh, input int kind,
                          input int abort_edge, input int pulse_edge,
                          output int nd_edge, output logic [OUT_W-1:0] dout,
                          output logic dsat, output logic busy_e0,
                          output logic busy_abort, output logic busy_end);
    int n;
    n = 1 << ((osr_in < 2) ? 2 : (osr_in > 10) ? 10 : osr_in);
    nd_edge    = -1;
    dout       = '0;
    dsat       = 1'b0;
    busy_e0    = 1'b0;
    busy_abort = 1'b1;
    busy_end   = 1'b1;
    @(negedge clk);
    osr_log2 = 4'(osr_in);
    shift    = 5'(sh);
    for (int e = 0; e <= n + 20; e++) begin
      start = (e == 0) || (e == pulse_edge);
      if (abort_edge > 0 && e == abort_edge) enable = 1'b0;
      data_in = (e >= 2 && e <= n + 1) ? pat(kind, e - 1, n) : 1'b0;
      @(posedge clk);
      @(negedge clk);
      if (e == 0) busy_e0 = busy;
      if (e == abort_edge) busy_abort = busy;
      if (new_data && nd_edge < 0) begin
        nd_edge = e;
        dout    = data_out;
        dsat    = sat;
      end
      busy_end = busy;
      if (nd_edge >= 0 && e >= nd_edge + 3) break;
    end
    start   = 1'b0;
    data_in = 1'b0;
    enable  = 1'b1;
  endtask

  task automatic test_reset;
    total++; if (int_rst !== 1'b1) begin bad++; $display("FAIL reset_int_rst got=%b exp=1", int_rst); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (data_out !== 12'd0) begin bad++; $display("FAIL reset_data_out got=%0d exp=0", data_out); end
    total++; if (new_data !== 1'b0) begin bad++; $display("FAIL reset_new_data got=%b exp=0", new_data); end
    total++; if (sat !== 1'b0) begin bad++; $display("FAIL reset_sat got=%b exp=0", sat); end
  endtask

  task automatic test_full_scale;
    int nd; logic [OUT_W-1:0] d; logic s, b0, ba, be;
    run_conv(9, 6, 1, 0, 300, nd, d, s, b0, ba, be);
    total++; if (d !== 12'd2052) begin bad++; $display("FAIL fs_data got=%0d exp=2052", d); end
    total++; if (s !== 1'b0) begin bad++; $display("FAIL fs_sat got=%b exp=0", s); end
    total++; if (nd !== 514) begin bad++; $display("FAIL fs_new_data_edge got=%0d exp=514", nd); end
    total++; if (b0 !== 1'b1) begin bad++; $display("FAIL fs_busy_rise got=%b exp=1", b0); end
    total++; if (be !== 1'b0) begin bad++; $display("FAIL fs_busy_end got=%b exp=0", be); end
  endtask

  task automatic test_impulse;
    int nd; logic [OUT_W-1:0] d; logic s, b0, ba, be;
    run_conv(9, 0, 2, 0, 0, nd, d, s, b0, ba, be);
    total++; if (d !== 12'd512) begin bad++; $display("FAIL imp_first got=%0d exp=512", d); end
    run_conv(9, 0, 3, 0, 0, nd, d, s, b0, ba, be);
    total++; if (d !== 12'd1) begin bad++; $display("FAIL imp_last got=%0d exp=1", d); end
    run_conv(9, 0, 0, 0, 0, nd, d, s, b0, ba, be);
    total++; if (d !== 12'd0) begin bad++; $display("FAIL imp_zeros got=%0d exp=0", d); end
    total++; if (nd !== 514) begin bad++; $display("FAIL imp_zeros_edge got=%0d exp=514", nd); end
  endtask

  task automatic test_saturation;
    int nd; logic [OUT_W-1:0] d; logic s, b0, ba, be;
    run_conv(9, 0, 1, 0, 0, nd, d, s, b0, ba, be);
    total++; if (d !== 12'd4095) begin bad++; $display("FAIL sat_data got=%0d exp=4095", d); end
    total++; if (s !== 1'b1) begin bad++; $display("FAIL sat_flag got=%b exp=1", s); end
  endtask

  task automatic test_continuous;
    int nd_cnt;
    int r;
    logic exp_ir;
    nd_cnt = 0;
    @(negedge clk);
    osr_log2 = 4'd4;
    shift    = 5'd0;
    start    = 1'b0;
    mode     = 1'b1;
    for (int e = 0; e <= 80; e++) begin
      if (e == 55) mode = 1'b0;
      r = (e >= 1) ? (e - 1) % 18 : 0;
      data_in = (e >= 1 && r >= 1 && r <= 16) ? ((r % 2) == 1) : 1'b0;
      @(posedge clk);
      @(negedge clk);
      exp_ir = !(e <= 72 && (e % 18) >= 1 && (e % 18) <= 16);
      total++;
      if (int_rst !== exp_ir) begin
        bad++; $display("FAIL cont_int_rst edge=%0d got=%b exp=%b", e, int_rst, exp_ir);
      end
      if (new_data) begin
        nd_cnt++;
        total++;
        if (data_out !== 12'd72) begin bad++; $display("FAIL cont_data got=%0d exp=72", data_out); end
        total++;
        if (e !== 18 * nd_cnt) begin bad++; $display("FAIL cont_edge got=%0d exp=%0d", e, 18 * nd_cnt); end
      end
    end
    data_in = 1'b0;
    total++; if (nd_cnt !== 4) begin bad++; $display("FAIL cont_count got=%0d exp=4", nd_cnt); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL cont_stop_busy got=%b exp=0", busy); end
  endtask

  task automatic test_abort;
    int nd; logic [OUT_W-1:0] d; logic s, b0, ba, be;
    run_conv(9, 0, 1, 102, 0, nd, d, s, b0, ba, be);
    total++; if (nd !== -1) begin bad++; $display("FAIL abort_new_data got=%0d exp=-1", nd); end
    total++; if (ba !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b exp=0", ba); end
    total++; if (data_out !== 12'd72) begin bad++; $display("FAIL abort_held got=%0d exp=72", data_out); end
    total++; if (sat !== 1'b0) begin bad++; $display("FAIL abort_sat got=%b exp=0", sat); end
  endtask

  task automatic test_osr_clamp;
    int nd; logic [OUT_W-1:0] d; logic s, b0, ba, be;
    run_conv(0, 0, 1, 0, 0, nd, d, s, b0, ba, be);
    total++; if (nd !== 6) begin bad++; $display("FAIL clamp_lo_edge got=%0d exp=6", nd); end
    total++; if (d !== 12'd10) begin bad++; $display("FAIL clamp_lo_data got=%0d exp=10", d); end
    run_conv(15, 8, 1, 0, 0, nd, d, s, b0, ba, be);
    total++; if (nd !== 1026) begin bad++; $display("FAIL clamp_hi_edge got=%0d exp=1026", nd); end
    total++; if (d !== 12'd2050) begin bad++; $display("FAIL clamp_hi_data got=%0d exp=2050", d); end
  endtask

  task automatic test_async_reset;
    @(negedge clk);
    osr_log2 = 4'd9;
    shift    = 5'd0;
    start    = 1'b1;
    for (int e = 0; e < 200; e++) begin
      data_in = (e >= 2);
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
    end
    total++; if (int_rst !== 1'b0) begin bad++; $display("FAIL arst_pre_int_rst got=%b exp=0", int_rst); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (int_rst !== 1'b1) begin bad++; $display("FAIL arst_int_rst got=%b exp=1", int_rst); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL arst_busy got=%b exp=0", busy); end
    total++; if (data_out !== 12'd0) begin bad++; $display("FAIL arst_data_out got=%0d exp=0", data_out); end
    total++; if (sat !== 1'b0) begin bad++; $display("FAIL arst_sat got=%b exp=0", sat); end
    total++; if (new_data !== 1'b0) begin bad++; $display("FAIL arst_new_data got=%b exp=0", new_data); end
    @(negedge clk);
    rst_n   = 1'b1;
    data_in = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL arst_idle_busy got=%b exp=0", busy); end
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    rst_n    = 1'b0;
    enable   = 1'b1;
    mode     = 1'b0;
    start    = 1'b0;
    osr_log2 = 4'd0;
    shift    = 5'd0;
    data_in  = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    test_full_scale();
    test_impulse();
    test_saturation();
    test_continuous();
    test_abort();
    test_osr_clamp();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
